// File: rtl/cell_frame_feeder.sv
// cell_frame_feeder: per-frame raster streamer of grid cells with pattern colours and a valid/ready handshake
//   vclock, reset_n        : pixel clock, asynchronous active-low reset
//   frame_start            : one-cycle pulse that starts a scan when idle
//   mode, fg_rgb, bg_rgb   : pattern select and colours, latched at scan start
//   cell_valid/cell_ready  : handshake for cell_x, cell_y, cell_rgb
//   update                 : one-cycle pulse after the last cell is accepted
//   busy, overrun          : scan in progress, sticky frame_start-while-busy flag
//   tick_count             : animation phase, advances every FRAMES_PER_TICK frames
module cell_frame_feeder #(
    parameter int GRID_WIDTH      = 20,
    parameter int GRID_HEIGHT     = 15,
    parameter int B_WIDTH         = $clog2(GRID_WIDTH - 1),
    parameter int B_HEIGHT        = $clog2(GRID_HEIGHT - 1),
    parameter int B_VGA           = 4,
    parameter int FRAMES_PER_TICK = 60
) (
    input  logic                  vclock,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic [1:0]            mode,
    input  logic [3*B_VGA-1:0]    fg_rgb,
    input  logic [3*B_VGA-1:0]    bg_rgb,
    output logic                  cell_valid,
    input  logic                  cell_ready,
    output logic [B_WIDTH-1:0]    cell_x,
    output logic [B_HEIGHT-1:0]   cell_y,
    output logic [3*B_VGA-1:0]    cell_rgb,
    output logic                  update,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            tick_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam int FW = FRAMES_PER_TICK > 1 ? $clog2(FRAMES_PER_TICK) : 1;

    logic [0:0]           state;
    logic [FW-1:0]        frame_cnt;
    logic [1:0]           f_mode;
    logic [3*B_VGA-1:0]   f_fg, f_bg;
    logic [7:0]           f_tick;
    logic                 xfer, last_x, last_cell;
    logic [B_WIDTH-1:0]   nx;
    logic [B_HEIGHT-1:0]  ny;

    function automatic logic [3*B_VGA-1:0] colour(
        input logic [1:0]          m,
        input logic [3*B_VGA-1:0]  fg,
        input logic [3*B_VGA-1:0]  bg,
        input logic [7:0]          p,
        input logic [B_WIDTH-1:0]  x,
        input logic [B_HEIGHT-1:0] y
    );
        logic [B_VGA-1:0] r, g;
        r = B_VGA'(32'(x) + 32'(p));
        g = B_VGA'(32'(y) + 32'(p));
        return m == 2'd0 ? fg :
               m == 2'd1 ? ((x[0] ^ y[0]) ? fg : bg) :
               m == 2'd2 ? {r, g, fg[B_VGA-1:0]} :
               (32'(x) == 32'(p) % 32'(GRID_WIDTH)) ? fg : bg;
    endfunction

    assign busy      = state;
    assign xfer      = cell_valid && cell_ready;
    assign last_x    = cell_x == B_WIDTH'(GRID_WIDTH - 1);
    assign last_cell = last_x && cell_y == B_HEIGHT'(GRID_HEIGHT - 1);
    assign nx        = last_x ? '0 : cell_x + 1'b1;
    assign ny        = last_x ? cell_y + 1'b1 : cell_y;

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            tick_count <= '0;
            f_mode     <= '0;
            f_fg       <= '0;
            f_bg       <= '0;
            f_tick     <= '0;
            cell_valid <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            cell_rgb   <= '0;
            update     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            update <= 1'b0;
            // every frame_start advances the animation, even one ignored by a running scan
            if (frame_start) begin
                frame_cnt  <= frame_cnt == FW'(FRAMES_PER_TICK - 1) ? '0 : frame_cnt + 1'b1;
                tick_count <= frame_cnt == FW'(FRAMES_PER_TICK - 1) ? tick_count + 1'b1 : tick_count;
            end
            if (state == IDLE) begin
                if (frame_start) begin
                    state      <= SCAN;
                    f_mode     <= mode;
                    f_fg       <= fg_rgb;
                    f_bg       <= bg_rgb;
                    f_tick     <= tick_count;
                    cell_valid <= 1'b1;
                    cell_x     <= '0;
                    cell_y     <= '0;
                    // first cell uses the live inputs since the frame copies load on this same edge
                    cell_rgb   <= colour(mode, fg_rgb, bg_rgb, tick_count, '0, '0);
                end
            end else begin
                if (frame_start)
                    overrun <= 1'b1;
                if (xfer && last_cell) begin
                    state      <= IDLE;
                    cell_valid <= 1'b0;
                    cell_x     <= '0;
                    cell_y     <= '0;
                    update     <= 1'b1;
                end else if (xfer) begin
                    cell_x   <= nx;
                    cell_y   <= ny;
                    cell_rgb <= colour(f_mode, f_fg, f_bg, f_tick, nx, ny);
                end
            end
        end
    end
endmodule

// File: tb/tb_cell_frame_feeder.sv
// tb_cell_frame_feeder: randomized scoreboard bench for cell_frame_feeder against a frame-level reference model
module tb_cell_frame_feeder;
    localparam int W   = 20;
    localparam int H   = 15;
    localparam int BV  = 4;
    localparam int FPT = 2;
    localparam int BW  = $clog2(W - 1);
    localparam int BH  = $clog2(H - 1);
    localparam int CW  = 3 * BV;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          frame_start = 1'b0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] fg_rgb = '0, bg_rgb = '0;
    logic          cell_valid, cell_ready = 1'b1;
    logic [BW-1:0] cell_x;
    logic [BH-1:0] cell_y;
    logic [CW-1:0] cell_rgb;
    logic          update, busy, overrun;
    logic [7:0]    tick_count;

    cell_frame_feeder #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .B_VGA(BV), .FRAMES_PER_TICK(FPT)) dut (
        .vclock(clk), .reset_n(reset_n), .frame_start(frame_start), .mode(mode),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_y(cell_y), .cell_rgb(cell_rgb), .update(update),
        .busy(busy), .overrun(overrun), .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    logic [BW+BH+CW-1:0] q[$];
    int n_checks = 0, n_fail = 0;
    int m_tick = 0, m_fcnt = 0, exp_updates = 0, upd_seen = 0;
    logic exp_overrun = 1'b0;
    int rmode = 0;
    logic [CW-1:0] last53 = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] ref_rgb(input int m, input logic [CW-1:0] fg, input logic [CW-1:0] bg,
                                              input int p, input int x, input int y);
        logic [BV-1:0] r, g;
        r = BV'((x + p) % (1 << BV));
        g = BV'((y + p) % (1 << BV));
        case (m)
            0:       return fg;
            1:       return ((x ^ y) & 1) != 0 ? fg : bg;
            2:       return {r, g, fg[BV-1:0]};
            default: return x == p % W ? fg : bg;
        endcase
    endfunction

    // called at posedge+1; frame_start is sampled on the following edge
    task automatic start_frame(input logic [1:0] m, input logic [CW-1:0] fg, input logic [CW-1:0] bg);
        bit was_busy;
        int p;
        mode = m; fg_rgb = fg; bg_rgb = bg; frame_start = 1'b1;
        was_busy = q.size() != 0;
        p = m_tick;
        @(posedge clk); #1;
        frame_start = 1'b0;
        m_fcnt++;
        if (m_fcnt == FPT) begin m_fcnt = 0; m_tick = (m_tick + 1) % 256; end
        if (was_busy) exp_overrun = 1'b1;
        else begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    q.push_back({BW'(x), BH'(y), ref_rgb(int'(m), fg, bg, p, x, y)});
            exp_updates++;
        end
        mode = 2'($urandom); fg_rgb = CW'($urandom); bg_rgb = CW'($urandom);
    endtask

    task automatic wait_size(input int s);
        int n = 0;
        while (q.size() > s && n < 5000) begin @(posedge clk); #1; n++; end
        check("wait_timeout", 32'(n < 5000), 32'd1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        cell_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ~cell_ready : 1'($urandom);
    end

    initial begin
        logic pv = 0, pr = 0, pu = 0;
        logic [BW-1:0] px = '0;
        logic [BH-1:0] py = '0;
        logic [CW-1:0] prgb = '0;
        logic [BW+BH+CW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin pv = 0; pu = 0; continue; end
            if (pv && !pr)
                check("hold", 32'({cell_valid, cell_x, cell_y, cell_rgb}), 32'({pv, px, py, prgb}));
            check("busy", 32'(busy), 32'(q.size() != 0));
            check("valid", 32'(cell_valid), 32'(q.size() != 0));
            check("tick", 32'(tick_count), 32'(m_tick));
            check("overrun", 32'(overrun), 32'(exp_overrun));
            if (cell_valid && cell_ready && q.size() != 0) begin
                e = q.pop_front();
                check("cell", 32'({cell_x, cell_y, cell_rgb}), 32'(e));
                if (cell_x == 5 && cell_y == 3) last53 = cell_rgb;
            end
            if (update) begin
                check("update_once", 32'(pu), 32'd0);
                upd_seen++;
            end
            pv = cell_valid; pr = cell_ready; pu = update;
            px = cell_x; py = cell_y; prgb = cell_rgb;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        #1 reset_n = 1'b0;
        #2;
        check("rst_valid", 32'(cell_valid), 0);
        check("rst_xy_rgb", 32'({cell_x, cell_y, cell_rgb}), 0);
        check("rst_flags", 32'({update, busy, overrun}), 0);
        check("rst_tick", 32'(tick_count), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        rmode = 0;
        start_frame(2'd0, 12'hF00, 12'h0F0);
        i = 0;
        do begin @(negedge clk); i++; end while (!update && i < 400);
        check("update_latency", 32'(i), 32'd301);
        wait_size(0);

        rmode = 1;
        start_frame(2'd1, 12'hFFF, 12'h000);
        wait_size(0);

        rmode = 2;
        repeat (6) begin
            start_frame(2'd3, CW'($urandom), CW'($urandom));
            wait_size(0);
            repeat (3) @(posedge clk);
            #1;
        end

        rmode = 0;
        start_frame(2'd2, CW'($urandom), CW'($urandom));
        wait_size(200);
        i = 0;
        while (m_tick != 14 && i < 100) begin start_frame(2'd0, 12'h123, 12'h456); i++; end
        check("tick_reached", 32'(m_tick), 32'd14);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_size(0);
        start_frame(2'd2, 12'hABC, 12'h000);
        wait_size(0);
        check("mode2_cell_5_3", 32'(last53), 32'h31C);

        start_frame(2'd1, CW'($urandom), CW'($urandom));
        wait_size(1);
        start_frame(2'd3, CW'($urandom), CW'($urandom));
        start_frame(2'd3, CW'($urandom), CW'($urandom));
        wait_size(0);

        rmode = 2;
        repeat (3) begin
            start_frame(2'($urandom), CW'($urandom), CW'($urandom));
            wait_size(0);
        end

        rmode = 0;
        start_frame(2'd1, 12'hFFF, 12'h00F);
        wait_size(150);
        #2 reset_n = 1'b0;
        q.delete();
        exp_updates--;
        m_tick = 0; m_fcnt = 0; exp_overrun = 1'b0;
        #1;
        check("midrst_valid", 32'(cell_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_update", 32'(update), 0);
        check("midrst_tick", 32'(tick_count), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        start_frame(2'd3, 12'h0F0, 12'h00F);
        @(negedge clk);
        check("restart_xy", 32'({cell_valid, cell_x, cell_y}), 32'({1'b1, BW'(0), BH'(0)}));
        wait_size(0);
        repeat (3) @(posedge clk);
        check("updates", 32'(upd_seen), 32'(exp_updates));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cell_frame_feeder.md
# cell_frame_feeder

Parametrised per-frame cell streamer that sits between the VGA timing generator and `matrix_display`. On each frame-start pulse it scans every cell of a GRID_WIDTH x GRID_HEIGHT grid in raster order. For each cell it presents a coordinate and an RGB value generated by a selectable pattern mode, using a valid/ready handshake. After the last cell it issues a one-cycle `update` pulse. A frame/tick counter animates the patterns.

## Interface
Parameters:
- GRID_WIDTH, 20, cells per row (>=2)
- GRID_HEIGHT, 15, cells per column (>=2)
- B_WIDTH, $clog2(GRID_WIDTH-1), width of `cell_x`
- B_HEIGHT, $clog2(GRID_HEIGHT-1), width of `cell_y`
- B_VGA, 4, bits per colour channel; `cell_rgb` is 3*B_VGA wide, packed {r,g,b}
- FRAMES_PER_TICK, 60, frames per animation tick (>=1)

Ports:
- vclock  in  1  single clock (65 MHz pixel clock)
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse (hcount==0 && vcount==0)
- mode  in  2  0 solid, 1 checker, 2 gradient, 3 moving column bar
- fg_rgb  in  3*B_VGA  foreground colour
- bg_rgb  in  3*B_VGA  background colour
- cell_valid  out  1  cell data valid
- cell_ready  in  1  consumer accepts the cell this cycle
- cell_x  out  B_WIDTH  column of the presented cell
- cell_y  out  B_HEIGHT  row of the presented cell
- cell_rgb  out  3*B_VGA  colour of the presented cell
- update  out  1  one-cycle pulse after the last cell is accepted
- busy  out  1  scan in progress
- overrun  out  1  sticky; frame_start arrived while busy
- tick_count  out  8  animation phase, wraps 255->0

## Operation
- The block has two states, IDLE and SCAN.
- IDLE -> SCAN on `frame_start`:
  - latch `mode`, `fg_rgb`, `bg_rgb` and `tick_count` into frame-local copies
  - set x=0, y=0, `cell_valid`=1
- SCAN: a transfer occurs when `cell_valid && cell_ready`.
  - x increments on each transfer.
  - At x==GRID_WIDTH-1, x wraps to 0 and y increments.
  - While `cell_ready`=0, `cell_x`, `cell_y`, `cell_rgb` and `cell_valid` hold stable.
- Transfer of (GRID_WIDTH-1, GRID_HEIGHT-1) moves SCAN -> IDLE. On that edge: `cell_valid`<=0, x,y<=0, `update`<=1 for exactly one cycle.
- Colour per cell uses the frame-latched values, with P = latched tick:
  - mode 0: fg
  - mode 1: ((x^y)&1) ? fg : bg
  - mode 2: r=(x+P) mod 2^B_VGA, g=(y+P) mod 2^B_VGA, b=fg.b
  - mode 3: (x == P mod GRID_WIDTH) ? fg : bg
- Frame counter:
  - increments on every `frame_start`, including ignored ones
  - at FRAMES_PER_TICK-1 it wraps to 0 and `tick_count` increments
- `frame_start` while in SCAN: ignored for scanning, the scan continues unchanged, and `overrun`<=1. `overrun` is cleared only by reset.
- `busy` = (state==SCAN).

## Timing
- Reset (async, reset_n=0) values: state IDLE, `cell_valid`=0, `cell_x`=0, `cell_y`=0, `cell_rgb`=0, `update`=0, `busy`=0, `overrun`=0, `tick_count`=0, frame counter 0.
- Scan start: `frame_start` high at edge N -> `cell_valid`=1 with (0,0) and its colour after edge N.
- Throughput: with `cell_ready` held high, one cell per cycle. The final transfer occurs at edge N+GRID_WIDTH*GRID_HEIGHT, and `update`=1 and `busy`=0 in the following cycle.
- A `frame_start` coincident with the final transfer edge counts as an overrun and is not started. A `frame_start` in the `update` cycle starts a new scan.
- All outputs are registered; there is no combinational path from `cell_ready` to any output.
- reset_n asserted mid-scan: immediate return to reset values, with no `update` pulse.
- Colour change mid-scan has no effect: `mode`/`fg_rgb`/`bg_rgb` changes take effect from the next scan.

## Test plan
- Default params, mode 0, fg=12'hF00, ready=1, one frame_start -> 300 transfers in raster order (0,0)..(19,14), all 12'hF00; update one cycle, 301 cycles after the frame_start edge.
- Mode 1, fg=12'hFFF, bg=12'h000, ready toggling 1/0 every cycle -> checker pattern with (0,0)=000 and (1,0)=FFF; outputs stable while ready=0; 300 transfers; single update.
- FRAMES_PER_TICK=2, mode 3, six frame_starts spaced 400 cycles apart -> tick_count goes 0,0,1,1,2,2 at scan start; lit column x=0,0,1,1,2,2.
- Mode 2 with tick=14, B_VGA=4 -> cell (5,3) r=4'h3, g=4'h1, b=fg.b (wrap-around check).
- frame_start pulsed at cell 100 of a scan -> scan completes normally with 300 transfers; overrun=1 and stays 1; the frame counter still increments.
- reset_n low at cell 150 -> cell_valid, busy and update go 0 immediately; the next frame_start after release restarts at (0,0) with tick_count=0.
